mips_multicycle_ctrl: RTL
=========================

// Module: mips_multicycle_ctrl
// PURPOSE
//  Multi-cycle MIPS control FSM; the initiator that drives the ALU's ALUOP/operand selects and consumes its ZeroFlag.
//  Sequences fetch/decode/execute/memory/writeback per instruction; emits datapath enables and mux selects.
//  Sits between the IR fields (Opcode/Funct) and the datapath; memory accesses use a MemReady handshake.
// PARAMETERS
//  MEM_WAIT_MAX  16  cycles a memory state may wait on MemReady=0 before MemTimeout is set (1..255)
// PORTS
//  Clk        in   1  clock, all state changes on rising edge
//  RstN       in   1  asynchronous, active-low reset
//  Opcode     in   6  IR[31:26], valid from DECODE onward
//  Funct      in   6  IR[5:0]
//  ZeroFlag   in   1  ALU compare result (1 = beq/bne condition true)
//  MemReady   in   1  memory completes read/write this cycle
//  ALUOP      out  4  0010 add,0110 sub,0000 and,0001 or,0100 sll,0101 srl,0111 slt,1000 eq,1001 ne
//  ALUSrcA    out  2  00 PC, 01 A(rs), 10 B(rt)
//  ALUSrcB    out  3  000 B, 001 const 4, 010 SignImm, 011 SignImm<<2, 100 ZeroImm, 101 shamt
//  PCWrite    out  1  load PC;  PCSource out 2: 00 ALU result, 01 ALUOut, 10 jump target
//  IRWrite    out  1  load IR;  IorD out 1: 0 PC address, 1 ALUOut address
//  MemRead    out  1  / MemWrite out 1: memory request, held until MemReady
//  RegWrite   out  1  / RegDst out 1 (1 rd, 0 rt) / MemToReg out 1 (1 MDR, 0 ALUOut)
//  MemTimeout out  1  sticky: a memory wait reached MEM_WAIT_MAX
//  Trap       out  1  sticky illegal-instruction flag (0 when ILLEGAL_TRAP_EN undefined)
//  State      out  4  current state, debug
// BEHAVIOUR
//  States: IDLE0 FETCH1 DECODE2 MEMADR3 MEMRD4 MEMWB5 MEMWR6 EXEC7 ALUWB8 IEXEC9 IWB10 BRANCH11 JUMP12 TRAP13.
//  Reset (async, RstN=0): State=IDLE; every output 0 incl. sticky flags. IDLE->FETCH next cycle unconditionally.
//  Outputs decode from State (Moore) except IRWrite/PCWrite in FETCH and PCWrite in BRANCH (Mealy).
//  FETCH: MemRead=1,IorD=0,SrcA=00,SrcB=001,ALUOP=0010; waits while MemReady=0;
//   MemReady=1: IRWrite=1,PCWrite=1,PCSource=00 same cycle -> DECODE.
//  DECODE: SrcA=00,SrcB=011,ALUOP=0010 (branch target to ALUOut). Opcode: 00->EXEC, 23/2B->MEMADR,
//   04/05->BRANCH, 08/0A/0C/0D->IEXEC, 02->JUMP, else illegal.
//  MEMADR: SrcA=01,SrcB=010,ALUOP=0010 -> MEMRD (lw) / MEMWR (sw).
//  MEMRD: MemRead=1,IorD=1; MemReady -> MEMWB. MEMWB: RegWrite=1,RegDst=0,MemToReg=1 -> FETCH.
//  MEMWR: MemWrite=1,IorD=1; MemReady -> FETCH (no writeback).
//  EXEC: Funct 20/22/24/25/2A -> ALUOP add/sub/and/or/slt, SrcA=01,SrcB=000;
//   Funct 00/02 -> sll/srl, SrcA=10,SrcB=101; other Funct illegal. -> ALUWB: RegWrite=1,RegDst=1,MemToReg=0 -> FETCH.
//  IEXEC: SrcA=01; addi add/SrcB=010, slti slt/010, andi and/100, ori or/100 -> IWB: RegWrite=1,RegDst=0 -> FETCH.
//  BRANCH: SrcA=01,SrcB=000,ALUOP=1000 (beq)/1001 (bne); PCWrite=ZeroFlag,PCSource=01 -> FETCH.
//  JUMP: PCWrite=1,PCSource=10 -> FETCH.
//  Wait counter: 8b, cleared on entering FETCH/MEMRD/MEMWR and on MemReady; +1 per MemReady=0 cycle there;
//   reaching MEM_WAIT_MAX sets MemTimeout; counter saturates; FSM keeps waiting (no abort).
//  MemReady outside FETCH/MEMRD/MEMWR ignored. Reset mid-access drops MemRead/MemWrite asynchronously.
//  Never PCWrite and RegWrite in the same cycle; MemRead and MemWrite never both 1.
// CONFIGURATION
//  MIPS_CTRL_ILLEGAL_TRAP_EN defined: illegal opcode/funct -> TRAP; Trap=1 sticky; TRAP holds, all enables 0,
//   exits only via reset. Undefined: illegal treated as NOP -> FETCH next cycle; Trap tied 0; TRAP unreachable.
// STRUCTURE
//  Package mips_ctrl_pkg: opcode/funct localparams, ALUOP codes, SrcA/SrcB/PCSource encodings, state encoding.
//  Sub-module alu_op_decode: combinational {Opcode,Funct,State} -> {ALUOP,SrcB sel,illegal}.
//  Top holds state register, wait counter, sticky flags, output decode.
// TESTING
//  lw (Opcode 23), MemReady low 2 cycles in FETCH and MEMRD -> IDLE,F,F,F,DEC,MADR,MRD x3,MWB,FETCH; RegWrite=1,MemToReg=1 once.
//  beq (04) ZeroFlag=1 -> BRANCH ALUOP=1000,PCWrite=1,PCSource=01; bne (05) ZeroFlag=0 -> ALUOP=1001,PCWrite=0.
//  R sll (Op 00,Funct 00) -> EXEC ALUOP=0100,SrcA=10,SrcB=101; ori (0D) -> IEXEC ALUOP=0001,SrcB=100.
//  MemReady held 0 in MEMWR, MEM_WAIT_MAX=4 -> MemTimeout=1 after 4 cycles, MemWrite stays 1, sticky after MemReady.
//  Opcode 3F: with macro -> TRAP,Trap=1, enables 0 until RstN; without -> FETCH next cycle, Trap=0.
//  RstN low during MEMRD wait -> all outputs 0 immediately; IDLE then FETCH after release.

Source files
------------

// File: rtl/mips_multicycle_ctrl_pkg.sv
// Package mips_ctrl_pkg: shared encodings for the multi-cycle MIPS controller.
//   - state_t     : FSM state encoding (also driven on the State debug port)
//   - OP_* / FN_* : recognised IR opcode and R-type funct values
//   - ALU_*       : ALUOP codes understood by the ALU
//   - SRCA_* / SRCB_* / PCSRC_* : datapath mux select encodings
//   - helpers     : memory-state test, shift-funct test, opcode legality
package mips_ctrl_pkg;

   typedef enum logic [3:0] {
      S_IDLE   = 4'd0,
      S_FETCH  = 4'd1,
      S_DECODE = 4'd2,
      S_MEMADR = 4'd3,
      S_MEMRD  = 4'd4,
      S_MEMWB  = 4'd5,
      S_MEMWR  = 4'd6,
      S_EXEC   = 4'd7,
      S_ALUWB  = 4'd8,
      S_IEXEC  = 4'd9,
      S_IWB    = 4'd10,
      S_BRANCH = 4'd11,
      S_JUMP   = 4'd12,
      S_TRAP   = 4'd13
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FN_SLL = 6'h00;
   localparam logic [5:0] FN_SRL = 6'h02;
   localparam logic [5:0] FN_ADD = 6'h20;
   localparam logic [5:0] FN_SUB = 6'h22;
   localparam logic [5:0] FN_AND = 6'h24;
   localparam logic [5:0] FN_OR  = 6'h25;
   localparam logic [5:0] FN_SLT = 6'h2A;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SLL = 4'b0100;
   localparam logic [3:0] ALU_SRL = 4'b0101;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;
   localparam logic [3:0] ALU_EQ  = 4'b1000;
   localparam logic [3:0] ALU_NE  = 4'b1001;

   localparam logic [1:0] SRCA_PC = 2'b00;
   localparam logic [1:0] SRCA_A  = 2'b01;
   localparam logic [1:0] SRCA_B  = 2'b10;

   localparam logic [2:0] SRCB_B        = 3'b000;
   localparam logic [2:0] SRCB_FOUR     = 3'b001;
   localparam logic [2:0] SRCB_SIGNIMM  = 3'b010;
   localparam logic [2:0] SRCB_SIMM_SH2 = 3'b011;
   localparam logic [2:0] SRCB_ZEROIMM  = 3'b100;
   localparam logic [2:0] SRCB_SHAMT    = 3'b101;

   localparam logic [1:0] PCSRC_ALU    = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
   localparam logic [1:0] PCSRC_JUMP   = 2'b10;

   // States that issue a memory request and wait on MemReady.
   function automatic logic is_mem_state(input state_t s);
      return (s == S_FETCH) || (s == S_MEMRD) || (s == S_MEMWR);
   endfunction

   function automatic logic is_shift_funct(input logic [5:0] fn);
      return (fn == FN_SLL) || (fn == FN_SRL);
   endfunction

   function automatic logic legal_opcode(input logic [5:0] op);
      case (op)
         OP_RTYPE, OP_J, OP_BEQ, OP_BNE, OP_ADDI, OP_SLTI,
         OP_ANDI, OP_ORI, OP_LW, OP_SW: return 1'b1;
         default:                       return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// mips_multicycle_ctrl_if: bundle between the control FSM and the datapath.
//   Datapath -> controller : Opcode, Funct, ZeroFlag, MemReady
//   Controller -> datapath : ALUOP, ALUSrcA, ALUSrcB, PCWrite, PCSource, IRWrite,
//                            IorD, MemRead, MemWrite, RegWrite, RegDst, MemToReg,
//                            MemTimeout, Trap, State
//   modport master : the controller side
//   modport slave  : the datapath side
interface mips_multicycle_ctrl_if;

   logic [5:0] Opcode;
   logic [5:0] Funct;
   logic       ZeroFlag;
   logic       MemReady;

   logic [3:0] ALUOP;
   logic [1:0] ALUSrcA;
   logic [2:0] ALUSrcB;
   logic       PCWrite;
   logic [1:0] PCSource;
   logic       IRWrite;
   logic       IorD;
   logic       MemRead;
   logic       MemWrite;
   logic       RegWrite;
   logic       RegDst;
   logic       MemToReg;
   logic       MemTimeout;
   logic       Trap;
   logic [3:0] State;

   modport master (
      input  Opcode, Funct, ZeroFlag, MemReady,
      output ALUOP, ALUSrcA, ALUSrcB, PCWrite, PCSource, IRWrite, IorD,
             MemRead, MemWrite, RegWrite, RegDst, MemToReg, MemTimeout, Trap, State
   );

   modport slave (
      output Opcode, Funct, ZeroFlag, MemReady,
      input  ALUOP, ALUSrcA, ALUSrcB, PCWrite, PCSource, IRWrite, IorD,
             MemRead, MemWrite, RegWrite, RegDst, MemToReg, MemTimeout, Trap, State
   );

endinterface

// File: rtl/mips_multicycle_ctrl_alu_op_decode.sv
// alu_op_decode: combinational ALU control for the multi-cycle controller.
//   opcode, funct : IR fields
//   state         : current controller state
//   aluop         : ALU operation for this state (0 when the ALU is unused)
//   srcb          : ALU operand-B select for this state
//   illegal       : unrecognised opcode (in DECODE) or funct (in EXEC)
module alu_op_decode
   import mips_ctrl_pkg::*;
(
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  state_t     state,
   output logic [3:0] aluop,
   output logic [2:0] srcb,
   output logic       illegal
);

   always_comb begin
      aluop   = '0;
      srcb    = '0;
      illegal = 1'b0;
      case (state)
         S_FETCH: begin
            aluop = ALU_ADD;
            srcb  = SRCB_FOUR;
         end
         S_DECODE: begin
            // Branch target is computed speculatively into ALUOut here.
            aluop   = ALU_ADD;
            srcb    = SRCB_SIMM_SH2;
            illegal = !legal_opcode(opcode);
         end
         S_MEMADR: begin
            aluop = ALU_ADD;
            srcb  = SRCB_SIGNIMM;
         end
         S_EXEC: begin
            case (funct)
               FN_ADD:  begin aluop = ALU_ADD; srcb = SRCB_B;     end
               FN_SUB:  begin aluop = ALU_SUB; srcb = SRCB_B;     end
               FN_AND:  begin aluop = ALU_AND; srcb = SRCB_B;     end
               FN_OR:   begin aluop = ALU_OR;  srcb = SRCB_B;     end
               FN_SLT:  begin aluop = ALU_SLT; srcb = SRCB_B;     end
               FN_SLL:  begin aluop = ALU_SLL; srcb = SRCB_SHAMT; end
               FN_SRL:  begin aluop = ALU_SRL; srcb = SRCB_SHAMT; end
               default: illegal = 1'b1;
            endcase
         end
         S_IEXEC: begin
            case (opcode)
               OP_ADDI: begin aluop = ALU_ADD; srcb = SRCB_SIGNIMM; end
               OP_SLTI: begin aluop = ALU_SLT; srcb = SRCB_SIGNIMM; end
               OP_ANDI: begin aluop = ALU_AND; srcb = SRCB_ZEROIMM; end
               OP_ORI:  begin aluop = ALU_OR;  srcb = SRCB_ZEROIMM; end
               default: ;
            endcase
         end
         S_BRANCH: begin
            aluop = (opcode == OP_BNE) ? ALU_NE : ALU_EQ;
            srcb  = SRCB_B;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: multi-cycle MIPS control FSM.
//   Clk  : clock, rising edge
//   RstN : asynchronous active-low reset; all outputs and sticky flags go to 0
//   bus  : mips_multicycle_ctrl_if.master (IR fields, ZeroFlag, MemReady in;
//          ALU/mux selects, enables, MemTimeout, Trap, State out)
// Parameter MEM_WAIT_MAX (1..255): MemReady=0 cycles in one memory state before
// MemTimeout (sticky) is raised; the FSM keeps waiting regardless.
// Build option MIPS_CTRL_ILLEGAL_TRAP_EN: illegal opcode/funct enters TRAP and
// sets sticky Trap; otherwise illegal instructions act as NOPs and Trap is 0.
module mips_multicycle_ctrl
   import mips_ctrl_pkg::*;
#(
   parameter int unsigned MEM_WAIT_MAX = 16
) (
   input  logic                  Clk,
   input  logic                  RstN,
   mips_multicycle_ctrl_if.master bus
);

   localparam logic [7:0] WAIT_MAX = 8'(MEM_WAIT_MAX);

`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
   localparam state_t ILLEGAL_NEXT = S_TRAP;
`else
   localparam state_t ILLEGAL_NEXT = S_FETCH;
`endif

   state_t     state, state_next;
   logic [7:0] wait_cnt;
   logic       mem_timeout;
   logic [3:0] dec_aluop;
   logic [2:0] dec_srcb;
   logic       dec_illegal;
   logic       in_mem, entering_mem;

   logic [1:0] ctl_srca, ctl_pcsrc;
   logic       ctl_pcwrite, ctl_irwrite, ctl_iord, ctl_memread, ctl_memwrite;
   logic       ctl_regwrite, ctl_regdst, ctl_memtoreg;

   alu_op_decode u_alu_op_decode (
      .opcode  (bus.Opcode),
      .funct   (bus.Funct),
      .state   (state),
      .aluop   (dec_aluop),
      .srcb    (dec_srcb),
      .illegal (dec_illegal)
   );

   always_ff @(posedge Clk or negedge RstN) begin
      if (!RstN) state <= S_IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:   state_next = S_FETCH;
         S_FETCH:  if (bus.MemReady) state_next = S_DECODE;
         S_DECODE: begin
            if (dec_illegal) begin
               state_next = ILLEGAL_NEXT;
            end else begin
               case (bus.Opcode)
                  OP_RTYPE:       state_next = S_EXEC;
                  OP_LW, OP_SW:   state_next = S_MEMADR;
                  OP_BEQ, OP_BNE: state_next = S_BRANCH;
                  OP_J:           state_next = S_JUMP;
                  default:        state_next = S_IEXEC;
               endcase
            end
         end
         S_MEMADR: state_next = (bus.Opcode == OP_LW) ? S_MEMRD : S_MEMWR;
         S_MEMRD:  if (bus.MemReady) state_next = S_MEMWB;
         S_MEMWB:  state_next = S_FETCH;
         S_MEMWR:  if (bus.MemReady) state_next = S_FETCH;
         S_EXEC:   state_next = dec_illegal ? ILLEGAL_NEXT : S_ALUWB;
         S_ALUWB:  state_next = S_FETCH;
         S_IEXEC:  state_next = S_IWB;
         S_IWB:    state_next = S_FETCH;
         S_BRANCH: state_next = S_FETCH;
         S_JUMP:   state_next = S_FETCH;
         S_TRAP:   state_next = S_TRAP;
         default:  state_next = S_IDLE;
      endcase
   end

   always_comb begin
      ctl_srca     = SRCA_PC;
      ctl_pcsrc    = PCSRC_ALU;
      ctl_pcwrite  = 1'b0;
      ctl_irwrite  = 1'b0;
      ctl_iord     = 1'b0;
      ctl_memread  = 1'b0;
      ctl_memwrite = 1'b0;
      ctl_regwrite = 1'b0;
      ctl_regdst   = 1'b0;
      ctl_memtoreg = 1'b0;
      case (state)
         S_FETCH: begin
            // IR and PC load in the same cycle the fetch completes.
            ctl_memread = 1'b1;
            ctl_irwrite = bus.MemReady;
            ctl_pcwrite = bus.MemReady;
         end
         S_MEMADR: ctl_srca = SRCA_A;
         S_MEMRD: begin
            ctl_memread = 1'b1;
            ctl_iord    = 1'b1;
         end
         S_MEMWB: begin
            ctl_regwrite = 1'b1;
            ctl_memtoreg = 1'b1;
         end
         S_MEMWR: begin
            ctl_memwrite = 1'b1;
            ctl_iord     = 1'b1;
         end
         S_EXEC:   ctl_srca = is_shift_funct(bus.Funct) ? SRCA_B : SRCA_A;
         S_ALUWB: begin
            ctl_regwrite = 1'b1;
            ctl_regdst   = 1'b1;
         end
         S_IEXEC:  ctl_srca = SRCA_A;
         S_IWB:    ctl_regwrite = 1'b1;
         S_BRANCH: begin
            ctl_srca    = SRCA_A;
            ctl_pcwrite = bus.ZeroFlag;
            ctl_pcsrc   = PCSRC_ALUOUT;
         end
         S_JUMP: begin
            ctl_pcwrite = 1'b1;
            ctl_pcsrc   = PCSRC_JUMP;
         end
         default: ;
      endcase
   end

   assign in_mem       = is_mem_state(state);
   assign entering_mem = is_mem_state(state_next) && (state_next != state);

   // Counter restarts on every entry to a memory state, so back-to-back
   // accesses (e.g. MEMWR -> FETCH) each get a fresh wait budget.
   always_ff @(posedge Clk or negedge RstN) begin
      if (!RstN) begin
         wait_cnt    <= '0;
         mem_timeout <= 1'b0;
      end else if (entering_mem) begin
         wait_cnt <= '0;
      end else if (in_mem) begin
         if (bus.MemReady) begin
            wait_cnt <= '0;
         end else begin
            if (wait_cnt != '1) wait_cnt <= wait_cnt + 8'd1;
            if (wait_cnt >= WAIT_MAX - 8'd1) mem_timeout <= 1'b1;
         end
      end
   end

`ifdef MIPS_CTRL_ILLEGAL_TRAP_EN
   logic trap_flag;

   always_ff @(posedge Clk or negedge RstN) begin
      if (!RstN)                    trap_flag <= 1'b0;
      else if (state_next == S_TRAP) trap_flag <= 1'b1;
   end

   assign bus.Trap = trap_flag;
`else
   assign bus.Trap = 1'b0;
`endif

   assign bus.ALUOP      = dec_aluop;
   assign bus.ALUSrcA    = ctl_srca;
   assign bus.ALUSrcB    = dec_srcb;
   assign bus.PCWrite    = ctl_pcwrite;
   assign bus.PCSource   = ctl_pcsrc;
   assign bus.IRWrite    = ctl_irwrite;
   assign bus.IorD       = ctl_iord;
   assign bus.MemRead    = ctl_memread;
   assign bus.MemWrite   = ctl_memwrite;
   assign bus.RegWrite   = ctl_regwrite;
   assign bus.RegDst     = ctl_regdst;
   assign bus.MemToReg   = ctl_memtoreg;
   assign bus.MemTimeout = mem_timeout;
   assign bus.State      = state;

endmodule
